bitstream_sync_checker: RTL and testbench
=========================================

Name: bitstream_sync_checker

Overview:
Sits between the SPI bitstream source mux (controller or receiver output) and the fabric configuration frame loader. It hunts for a sync word, reads a payload-length header and forwards exactly that many payload words downstream with one cycle of latency. It then compares a running checksum against a trailer word and reports done or error, so the fabric is only marked configured after a verified bitstream.

Parameters:
SYNC_WORD  32'hFAB0_FAB1  header word that starts a bitstream; all words before it are discarded
MAX_WORDS  32'h0000_1000  largest legal payload length; a length of 0 or above MAX_WORDS is an error
TIMEOUT_CYCLES  65536  largest allowed gap in clk_i cycles between valid words once the sync word is seen

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
data_i  input  32  bitstream word from the SPI source
valid_i  input  1  data_i qualifier; one cycle per word; no backpressure
clear_i  input  1  synchronous restart to HUNT from any state
data_o  output  32  forwarded payload word
valid_o  output  1  data_o qualifier; pulses only for payload words
busy_o  output  1  high in LENGTH, PAYLOAD and CHECK
done_o  output  1  sticky; payload received and checksum matched
error_o  output  1  sticky; bitstream rejected
error_code_o  output  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout

Behaviour:
- Reset is asynchronous and active-low. Reset values: state HUNT; data_o 0; valid_o 0; busy_o 0; done_o 0; error_o 0; error_code_o 0; all counters and the checksum 0.
- States: HUNT, LENGTH, PAYLOAD, CHECK, DONE, ERROR. busy_o is a registered decode of the state.
- HUNT: each valid word is compared with SYNC_WORD. On a match go to LENGTH and clear the checksum, word counter and timeout counter. Non-matching words are dropped.
- LENGTH: the valid word is latched as len.
  - len == 0 or len > MAX_WORDS: go to ERROR with code 1.
  - Otherwise: go to PAYLOAD with remaining = len.
  - The length word itself is not forwarded and not added to the checksum.
- PAYLOAD: each valid word is registered to data_o with valid_o = 1 on the next cycle (1-cycle latency). Each word updates the checksum: chk <= {chk[30:0], chk[31]} ^ data_i. remaining is decremented; on the word that brings remaining to 0, go to CHECK.
- CHECK: the next valid word is compared with chk (chk already includes the final payload word).
  - Equal: go to DONE and set done_o.
  - Not equal: go to ERROR with code 2.
  - The check word is never forwarded.
- DONE and ERROR are absorbing. Further valid words are ignored and valid_o stays 0 until clear_i or reset.
- Timeout: in LENGTH, PAYLOAD and CHECK, the counter increments on every cycle without valid_i and clears on valid_i. When the counter reaches TIMEOUT_CYCLES-1 with no valid_i, go to ERROR with code 3. A valid_i in that same cycle wins and is processed normally.
- done_o and error_o are never high together. error_code_o holds its value while in ERROR.
- clear_i has priority over valid_i in the same cycle. It returns the block to HUNT, clears done_o, error_o, error_code_o, the counters and chk, and drops the word presented that cycle. valid_o is 0 on the following cycle. This applies mid-PAYLOAD as well; words already forwarded are not recalled.
- A sync-word value arriving during PAYLOAD is treated as ordinary payload data.
- valid_o is 0 in every cycle except the one following an accepted payload word. data_o holds its last value otherwise.
- Downstream must drive "configured" from done_o, not from the end of the forwarded word stream.

Test Plan:
- Words 0x1234, FAB0FAB1, 2, 1, 2, 0 -> 0x1234 dropped; valid_o pulses twice with data 1 then 2, each one cycle after its input; done_o=1; error_o=0; busy_o=0 after the check word.
- FAB0FAB1, 2, 3, 5, check 0x4 -> checksum is 3, so ERROR with error_code_o=2; valid_o pulsed twice; done_o=0.
- FAB0FAB1, length 0 -> ERROR code 1. After clear_i, FAB0FAB1, length 0x1001 -> ERROR code 1. In both cases no valid_o pulse.
- FAB0FAB1, 2, 0x80000000, then no valid_i for TIMEOUT_CYCLES cycles -> ERROR code 3 exactly TIMEOUT_CYCLES cycles after the last word. A repeat run with valid_i arriving in cycle TIMEOUT_CYCLES-1 -> no error.
- clear_i asserted together with valid_i during PAYLOAD, then a full good stream (FAB0FAB1, 1, 0x7, 0x7) -> the word at the clear is dropped; the new stream forwards 0x7; done_o=1.
- Assert rst_ni low mid-PAYLOAD -> all outputs are 0 immediately, asynchronously; after release, HUNT ignores non-sync words.

Source files
------------

// File: rtl/bitstream_sync_checker.sv
// Bitstream framing checker: hunts for a sync word, reads a length header, forwards
// the payload with one cycle of latency and verifies a rotating-XOR checksum trailer.
`timescale 1ns/1ps
module bitstream_sync_checker #(
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [31:0] MAX_WORDS      = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o
);

  typedef enum logic [2:0] {HUNT, LENGTH, PAYLOAD, CHECK, DONE, ERROR} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] chk;
  logic [31:0] remaining;
  logic [31:0] tmo_cnt;
  logic        active;
  logic        tmo_hit;

  function automatic logic [31:0] chk_next(input logic [31:0] c, input logic [31:0] w);
    return {c[30:0], c[31]} ^ w;
  endfunction

  assign active  = (state == LENGTH) || (state == PAYLOAD) || (state == CHECK);
  // A word arriving in the last allowed cycle wins over the timeout.
  assign tmo_hit = active && !valid_i && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= HUNT;
      data_o       <= '0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      error_code_o <= 2'd0;
      chk          <= '0;
      remaining    <= '0;
      tmo_cnt      <= '0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        state        <= HUNT;
        busy_o       <= 1'b0;
        done_o       <= 1'b0;
        error_o      <= 1'b0;
        error_code_o <= 2'd0;
        chk          <= '0;
        remaining    <= '0;
        tmo_cnt      <= '0;
      end else if (tmo_hit) begin
        state        <= ERROR;
        busy_o       <= 1'b0;
        error_o      <= 1'b1;
        error_code_o <= 2'd3;
      end else begin
        if (active) begin
          tmo_cnt <= valid_i ? '0 : tmo_cnt + 32'd1;
        end
        case (state)
          HUNT: begin
            if (valid_i && (data_i == SYNC_WORD)) begin
              state     <= LENGTH;
              busy_o    <= 1'b1;
              chk       <= '0;
              remaining <= '0;
              tmo_cnt   <= '0;
            end
          end
          LENGTH: begin
            if (valid_i) begin
              if ((data_i == 32'd0) || (data_i > MAX_WORDS)) begin
                state        <= ERROR;
                busy_o       <= 1'b0;
                error_o      <= 1'b1;
                error_code_o <= 2'd1;
              end else begin
                state     <= PAYLOAD;
                remaining <= data_i;
              end
            end
          end
          PAYLOAD: begin
            if (valid_i) begin
              data_o    <= data_i;
              valid_o   <= 1'b1;
              chk       <= chk_next(chk, data_i);
              remaining <= remaining - 32'd1;
              if (remaining == 32'd1) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (valid_i) begin
              busy_o <= 1'b0;
              if (data_i == chk) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state        <= ERROR;
                error_o      <= 1'b1;
                error_code_o <= 2'd2;
              end
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_sync_checker.sv
// Scoreboard bench for bitstream_sync_checker: directed streams, forwarded words
// checked by a monitor against an expected queue, status flags checked inline.
`timescale 1ns/1ps
module tb_bitstream_sync_checker;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        valid;
  logic        clear;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  error_code_o;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  bitstream_sync_checker #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .clear_i(clear),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .error_code_o(error_code_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One word per cycle; fwd marks a word that must reappear on data_o.
  task automatic send(input logic [31:0] w, input bit fwd);
    data  = w;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (fwd) q.push_back('{w, cyc});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic status(input string tag, input logic d, input logic e,
                        input logic [1:0] code, input logic b);
    check({tag, "_done"}, 32'(done_o), 32'(d));
    check({tag, "_error"}, 32'(error_o), 32'(e));
    check({tag, "_code"}, 32'(error_code_o), 32'(code));
    check({tag, "_busy"}, 32'(busy_o), 32'(b));
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid_o: got data 0x%0h at cycle %0d, expected no output",
                 data_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fwd_data", data_o, e.data);
        check("fwd_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    status("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_data_o", data_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good stream with leading garbage; payload checksum is 0.
    send(32'h1234, 0);
    check("hunt_busy", 32'(busy_o), 32'd0);
    send(32'hFAB0_FAB1, 0);
    check("sync_busy", 32'(busy_o), 32'd1);
    send(32'd2, 0);
    send(32'd1, 1);
    send(32'd2, 1);
    check("check_state_busy", 32'(busy_o), 32'd1);
    send(32'd0, 0);
    status("good", 1'b1, 1'b0, 2'd0, 1'b0);
    send(32'hFAB0_FAB1, 0);
    send(32'd5, 0);
    status("done_absorb", 1'b1, 1'b0, 2'd0, 1'b0);

    // Checksum mismatch: chk = 3, trailer 4.
    do_clear();
    status("after_clear", 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'hFAB0_FAB1, 0);
    send(32'd2, 0);
    send(32'd3, 1);
    send(32'd5, 1);
    send(32'd4, 0);
    status("bad_chk", 1'b0, 1'b1, 2'd2, 1'b0);
    send(32'd9, 0);
    check("error_hold_code", 32'(error_code_o), 32'd2);

    // Bad lengths: 0 and MAX_WORDS+1; MAX_WORDS itself is accepted.
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'd0, 0);
    status("len0", 1'b0, 1'b1, 2'd1, 1'b0);
    do_clear();
    status("len_clear", 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'hFAB0_FAB1, 0);
    send(32'h1001, 0);
    status("len_big", 1'b0, 1'b1, 2'd1, 1'b0);
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'h1000, 0);
    status("len_max", 1'b0, 1'b0, 2'd0, 1'b1);

    // Timeout fires exactly T cycles after the last accepted word.
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'd2, 0);
    send(32'h8000_0000, 1);
    repeat (T - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", 32'(error_o), 32'd0);
    @(posedge clk);
    #1;
    status("tmo", 1'b0, 1'b1, 2'd3, 1'b0);

    // A word in the last allowed cycle wins; chk = rot(0x80000000)^5 = 4.
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'd2, 0);
    send(32'h8000_0000, 1);
    repeat (T - 1) @(posedge clk);
    #1;
    send(32'd5, 1);
    status("tmo_edge", 1'b0, 1'b0, 2'd0, 1'b1);
    send(32'd4, 0);
    status("tmo_edge_done", 1'b1, 1'b0, 2'd0, 1'b0);

    // Clear with a word mid-payload drops that word, then a fresh good stream.
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'd3, 0);
    send(32'h11, 1);
    data  = 32'h22;
    valid = 1'b1;
    do_clear();
    valid = 1'b0;
    check("clear_drop_valid_o", 32'(valid_o), 32'd0);
    status("clear_mid", 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'hFAB0_FAB1, 0);
    send(32'd1, 0);
    send(32'h7, 1);
    send(32'h7, 0);
    status("restart", 1'b1, 1'b0, 2'd0, 1'b0);

    // Asynchronous reset while a forwarded word is on the output.
    do_clear();
    send(32'hFAB0_FAB1, 0);
    send(32'd2, 0);
    send(32'hAA, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid_o", 32'(valid_o), 32'd0);
    check("arst_data_o", data_o, 32'd0);
    status("arst", 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd1, 0);
    send(32'd2, 0);
    check("post_rst_hunt_busy", 32'(busy_o), 32'd0);
    send(32'hFAB0_FAB1, 0);
    check("post_rst_sync_busy", 32'(busy_o), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
